spi_acl_responder: RTL and testbench
====================================

// Module: spi_acl_responder
// PURPOSE
//  SPI mode-0 responder emulating the accelerometer end of the ACL link. Decodes
//  cmd/addr/data frames from an SPI master, serves reads from a register file and
//  applies writes. Sits in sim benches and loopback builds opposite the SPI master top.
//  SCLK/SS/SDI are oversampled in the CLK domain.
// PARAMETERS
//  ADDR_W   6     register address bits; file depth 2**ADDR_W
//  DEVID    8'hAD read-only value of register 0x00
//  SYNC_FF  2     synchronizer depth on SCLK/SS/SDI, >=2
// PORTS
//  CLK        in   1  system clock; must be >= 8x SCLK frequency
//  RST        in   1  synchronous, active-high reset
//  SCLK       in   1  SPI clock from master, idle low (CPOL=0, CPHA=0)
//  SS         in   1  slave select, active low
//  SDI        in   1  master-out data
//  SDO        out  1  master-in data
//  smp_valid  in   1  one-cycle strobe: load smp_x/y/z into regs 0x08/0x09/0x0A
//  smp_x      in   8  X sample
//  smp_y      in   8  Y sample
//  smp_z      in   8  Z sample
//  pwr_ctl    out  8  live contents of register 0x2D
//  wr_stb     out  1  one-cycle pulse per committed SPI write
//  wr_addr    out  ADDR_W  address of committed write
//  wr_data    out  8  data of committed write
//  frame_done out  1  one-cycle pulse when SS deasserts after >=1 full byte
//  cmd_err    out  1  sticky; set on unknown command, cleared by RST only
// BEHAVIOUR
//  - Reset: SDO=0, pwr_ctl=0, wr_stb=0, wr_addr=0, wr_data=0, frame_done=0,
//    cmd_err=0; all registers 0 except 0x00=DEVID; FSM=IDLE; sync FFs cleared.
//  - Edge detect on synchronized SCLK: rise = sample SDI (MSB first), fall = shift SDO.
//  - FSM: IDLE -(SS low)-> CMD; CMD -(8 bits)-> ADDR if cmd 0x0A (write) or 0x0B
//    (read), else IGNORE + cmd_err=1; ADDR -(8 bits)-> WDATA or RDATA;
//    WDATA/RDATA loop per byte; IGNORE holds until SS high; any state -(SS high)-> IDLE.
//  - Address byte: low ADDR_W bits used; upper bits nonzero -> reads return 0x00, writes dropped.
//  - Write: on 8th rise of a data byte, reg[addr]<=byte, wr_stb pulses next cycle with
//    wr_addr/wr_data. Writes to 0x00, 0x08-0x0A ignored (read-only), no wr_stb.
//  - Read: on 8th rise of address (or data) byte, tx shift reg loads reg[addr], SDO=MSB
//    within 2 CLK, before next SCLK rise; remaining bits shift on falls.
//  - SDO=0 whenever SS high or FSM not in RDATA.
//  - smp_valid same cycle as SPI write: sample wins on 0x08-0x0A (SPI write is read-only
//    there anyway); read shift reg captures pre-load value if both hit in one cycle.
//  - SS high mid-byte: partial byte discarded, no write, bit counter cleared.
//  - RST mid-frame: immediate return to reset state; frame resumes only after SS high->low.
//  - Address wrap: 2**ADDR_W-1 increments to 0.
// CONFIGURATION
//  SPI_RESP_AUTOINC_EN defined: address increments by 1 after each data byte (burst
//    read/write). Undefined: address fixed for whole frame; repeated bytes hit same reg.
// TESTING
//  1 SS low, cmd 0x0B, addr 0x00, 8 SCLKs -> SDO byte 0xAD; frame_done on SS high.
//  2 cmd 0x0A, addr 0x2D, data 0x02 -> pwr_ctl=0x02, one wr_stb, wr_addr=0x2D, wr_data=0x02.
//  3 smp_valid with x=0x11,y=0x22,z=0x33; read burst 0x08 x3 -> 0x11,0x22,0x33 (AUTOINC_EN)
//    or 0x11,0x11,0x11 (not defined).
//  4 cmd 0x55, 16 more SCLKs -> SDO stays 0, cmd_err=1, no wr_stb.
//  5 write 0x2D, SS high after 5 data bits -> pwr_ctl unchanged, no wr_stb, no frame hang.
//  6 RST asserted mid-read -> SDO=0 next cycle, regs reset; next frame reads DEVID correctly.

Source files
------------

// File: rtl/spi_acl_responder.sv
`timescale 1ns/1ps
// SPI mode-0 responder for the accelerometer end of the ACL link: cmd/addr/data decode over a register file.
// Latency: ~3 CLK from an SCLK edge at the pins to its effect; wr_stb one CLK after the 8th data rise.
// Backpressure: none; the SPI master owns timing, so CLK must be >= 8x SCLK. Burst auto-increment under SPI_RESP_AUTOINC_EN.
module spi_acl_responder #(
  parameter int          ADDR_W  = 6,
  parameter logic [7:0]  DEVID   = 8'hAD,
  parameter int          SYNC_FF = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              SDI,
  output logic              SDO,
  input  logic              smp_valid,
  input  logic [7:0]        smp_x,
  input  logic [7:0]        smp_y,
  input  logic [7:0]        smp_z,
  output logic [7:0]        pwr_ctl,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              cmd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam logic [ADDR_W-1:0] A_DEV = '0;
  localparam logic [ADDR_W-1:0] A_X   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_Y   = ADDR_W'(8'h09);
  localparam logic [ADDR_W-1:0] A_Z   = ADDR_W'(8'h0A);
  localparam logic [ADDR_W-1:0] A_PWR = ADDR_W'(8'h2D);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t state, state_next;

  logic [SYNC_FF-1:0] sclk_sync, ss_sync, sdi_sync;
  logic sclk_s, ss_s, sdi_s, sclk_d, ss_d;
  logic rise, fall, ss_rise, ss_fall, active, byte_done;

  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sr, rx_next, tx_sr;
  logic [ADDR_W-1:0] addr, load_addr;
  logic              addr_bad, load_bad, hi_bad;
  logic              is_rd, got_byte, wr_ok, read_only;
  logic [7:0]        regs [DEPTH];

  assign sclk_s  = sclk_sync[SYNC_FF-1];
  assign ss_s    = ss_sync[SYNC_FF-1];
  assign sdi_s   = sdi_sync[SYNC_FF-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign ss_rise = ss_s & ~ss_d;
  assign ss_fall = ~ss_s & ss_d;

  // Bits only count once a frame has properly started (IDLE left on an SS fall).
  assign active    = (state != S_IDLE) && !ss_s;
  assign rx_next   = {rx_sr[6:0], sdi_s};
  assign byte_done = active && rise && (bit_cnt == 3'd7);
  assign hi_bad    = (rx_next >> ADDR_W) != 8'd0;
  assign read_only = (addr == A_DEV) || (addr == A_X) || (addr == A_Y) || (addr == A_Z);
  assign wr_ok     = byte_done && (state == S_WDATA) && !addr_bad && !read_only;

  assign pwr_ctl = regs[A_PWR];
  assign SDO     = (state == S_RDATA && !ss_s) ? tx_sr[7] : 1'b0;

  // Synchronize the SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_FF-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_FF-2:0], SS};
      sdi_sync  <= {sdi_sync[SYNC_FF-2:0], SDI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // Frame state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: SS high always wins and aborts the frame.
  always_comb begin
    state_next = state;
    if (ss_s) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (ss_fall) state_next = S_CMD;
        S_CMD:   if (byte_done)
                   state_next = (rx_next == CMD_WR || rx_next == CMD_RD) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (byte_done) state_next = is_rd ? S_RDATA : S_WDATA;
        default: state_next = state;
      endcase
    end
  end

  // Address for the next data byte: taken from the address byte, or advanced after a data byte in burst builds.
  always_comb begin
    load_addr = addr;
    load_bad  = addr_bad;
    if (state == S_ADDR) begin
      load_addr = rx_next[ADDR_W-1:0];
      load_bad  = hi_bad;
    end else begin
`ifdef SPI_RESP_AUTOINC_EN
      load_addr = addr + ADDR_W'(1);
`endif
    end
  end

  // Bit/byte shifting, address tracking and the read shift register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      addr     <= '0;
      addr_bad <= 1'b0;
      is_rd    <= 1'b0;
      got_byte <= 1'b0;
    end else if (!active) begin
      bit_cnt  <= '0;
      got_byte <= 1'b0;
    end else begin
      if (rise) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) got_byte <= 1'b1;
      if (byte_done && state == S_CMD) is_rd <= (rx_next == CMD_RD);
      if (byte_done && (state == S_ADDR || state == S_WDATA || state == S_RDATA)) begin
        addr     <= load_addr;
        addr_bad <= load_bad;
      end
      // Load on the 8th rise; the fall right after it (bit_cnt==0) keeps the MSB on SDO.
      if (byte_done && state_next == S_RDATA)
        tx_sr <= load_bad ? 8'h00 : regs[load_addr];
      else if (state == S_RDATA && fall && bit_cnt != 3'd0)
        tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  // Register file: one flop bank per entry; samples take priority over SPI writes.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    localparam logic [ADDR_W-1:0] GA = ADDR_W'(g);
    logic [7:0] q;
    assign regs[g] = q;
    // Entry update: reset value, sample load, or committed SPI write.
    always_ff @(posedge CLK) begin
      if (RST)                          q <= (GA == A_DEV) ? DEVID : 8'h00;
      else if (smp_valid && GA == A_X)  q <= smp_x;
      else if (smp_valid && GA == A_Y)  q <= smp_y;
      else if (smp_valid && GA == A_Z)  q <= smp_z;
      else if (wr_ok && addr == GA)     q <= rx_next;
    end
  end

  // Status outputs: write strobe, frame completion pulse, sticky command error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      wr_stb     <= wr_ok;
      frame_done <= ss_rise && got_byte;
      if (wr_ok) begin
        wr_addr <= addr;
        wr_data <= rx_next;
      end
      if (byte_done && state == S_CMD && rx_next != CMD_WR && rx_next != CMD_RD)
        cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_acl_responder.sv
`timescale 1ns/1ps
// Bench for spi_acl_responder: directed scenarios then random frames against a register-file model.
module tb_spi_acl_responder;
  localparam int  ADDR_W = 6;
  localparam time HALF   = 80;
`ifdef SPI_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, SCLK, SS, SDI, smp_valid;
  logic [7:0] smp_x, smp_y, smp_z;
  logic SDO, wr_stb, frame_done, cmd_err;
  logic [7:0] pwr_ctl, wr_data;
  logic [ADDR_W-1:0] wr_addr;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [64];
  bit m_err;
  logic [7:0] fb [8];

  int fd_cnt = 0;
  logic [ADDR_W-1:0] wq_a [$];
  logic [7:0] wq_d [$];

  spi_acl_responder #(.ADDR_W(ADDR_W), .DEVID(8'hAD), .SYNC_FF(2)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .SS(SS), .SDI(SDI), .SDO(SDO),
    .smp_valid(smp_valid), .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z),
    .pwr_ctl(pwr_ctl), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (wr_stb) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    mdl[0] = 8'hAD;
    m_err = 1'b0;
  endtask

  task automatic clk_bit(input logic b, output logic o);
    SDI = b;
    #(HALF);
    o = SDO;
    SCLK = 1'b1;
    #(HALF);
    SCLK = 1'b0;
  endtask

  task automatic load_smp(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge CLK);
    smp_x = x; smp_y = y; smp_z = z; smp_valid = 1'b1;
    @(negedge CLK);
    smp_valid = 1'b0;
    mdl[8] = x; mdl[9] = y; mdl[10] = z;
  endtask

  // Runs fb[0..fn-1] plus 'partial' extra bits as one frame and checks everything against the model.
  task automatic run_frame(input int fn, input int partial, input string tag);
    logic [7:0] rx [8];
    logic [7:0] exp_b, cmd, a;
    logic o;
    int fd0, ea;
    bit known, bad;
    logic [ADDR_W-1:0] e_a [$];
    logic [7:0] e_d [$];
    wq_a.delete();
    wq_d.delete();
    fd0 = fd_cnt;
    SS = 1'b0;
    #(HALF);
    for (int k = 0; k < fn; k++)
      for (int i = 7; i >= 0; i--) begin
        clk_bit(fb[k][i], o);
        rx[k][i] = o;
      end
    for (int p = 0; p < partial; p++) clk_bit(1'b1, o);
    #(HALF);
    SS = 1'b1;
    #(HALF * 2);

    cmd = fb[0];
    known = (cmd == 8'h0A) || (cmd == 8'h0B);
    if (!known) m_err = 1'b1;
    a = fb[1];
    bad = (a > 8'd63);
    for (int k = 0; k < fn; k++) begin
      exp_b = 8'h00;
      if (known && k >= 2) begin
        ea = (int'(a) + (AUTOINC ? k - 2 : 0)) % 64;
        if (cmd == 8'h0B) begin
          exp_b = bad ? 8'h00 : mdl[ea];
        end else if (!bad && ea != 0 && !(ea >= 8 && ea <= 10)) begin
          mdl[ea] = fb[k];
          e_a.push_back(ADDR_W'(ea));
          e_d.push_back(fb[k]);
        end
      end
      chk($sformatf("%s sdo_byte%0d", tag, k), 32'(rx[k]), 32'(exp_b));
    end
    chk({tag, " wr_stb_count"}, 32'(wq_a.size()), 32'(e_a.size()));
    for (int i = 0; i < e_a.size() && i < wq_a.size(); i++) begin
      chk($sformatf("%s wr_addr%0d", tag, i), 32'(wq_a[i]), 32'(e_a[i]));
      chk($sformatf("%s wr_data%0d", tag, i), 32'(wq_d[i]), 32'(e_d[i]));
    end
    chk({tag, " frame_done"}, 32'(fd_cnt - fd0), (fn > 0) ? 32'd1 : 32'd0);
    chk({tag, " pwr_ctl"}, 32'(pwr_ctl), 32'(mdl[45]));
    chk({tag, " cmd_err"}, 32'(cmd_err), 32'(m_err));
  endtask

  initial begin
    logic o;
    logic [7:0] byt;
    int fn, part, fd0;
    RST = 1'b1; SCLK = 1'b0; SS = 1'b1; SDI = 1'b0;
    smp_valid = 1'b0; smp_x = 8'h00; smp_y = 8'h00; smp_z = 8'h00;
    mdl_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset SDO", 32'(SDO), 32'd0);
    chk("reset pwr_ctl", 32'(pwr_ctl), 32'd0);
    chk("reset wr_stb", 32'(wr_stb), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_data", 32'(wr_data), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset cmd_err", 32'(cmd_err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Read of the device ID register.
    fb[0] = 8'h0B; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame(3, 0, "devid_read");
    // Write to the power-control register.
    fb[0] = 8'h0A; fb[1] = 8'h2D; fb[2] = 8'h02;
    run_frame(3, 0, "pwr_write");
    // Sample load then three-byte burst read starting at X.
    load_smp(8'h11, 8'h22, 8'h33);
    fb[0] = 8'h0B; fb[1] = 8'h08; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00;
    run_frame(5, 0, "smp_burst");
    // Unknown command followed by two more bytes.
    fb[0] = 8'h55; fb[1] = 8'h0B; fb[2] = 8'h00;
    run_frame(3, 0, "bad_cmd");
    // Write aborted five bits into the data byte, then confirm the next frame works.
    fb[0] = 8'h0A; fb[1] = 8'h2D;
    run_frame(2, 5, "partial_write");
    fb[0] = 8'h0B; fb[1] = 8'h2D; fb[2] = 8'h00;
    run_frame(3, 0, "after_partial");
    // Writes to a read-only register and to an out-of-range address.
    fb[0] = 8'h0A; fb[1] = 8'h09; fb[2] = 8'h77;
    run_frame(3, 0, "ro_write");
    fb[0] = 8'h0A; fb[1] = 8'h6D; fb[2] = 8'h44;
    run_frame(3, 0, "hi_addr_write");

    // Reset in the middle of a read with DEVID already on SDO.
    fd0 = fd_cnt;
    SS = 1'b0;
    #(HALF);
    byt = 8'h0B;
    for (int i = 7; i >= 0; i--) clk_bit(byt[i], o);
    byt = 8'h00;
    for (int i = 7; i >= 0; i--) clk_bit(byt[i], o);
    #(HALF / 2);
    chk("rst_mid pre SDO", 32'(SDO), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid SDO", 32'(SDO), 32'd0);
    chk("rst_mid pwr_ctl", 32'(pwr_ctl), 32'd0);
    chk("rst_mid cmd_err", 32'(cmd_err), 32'd0);
    RST = 1'b0;
    mdl_reset();
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, o);
      byt[i] = o;
    end
    chk("rst_mid rest SDO", 32'(byt), 32'd0);
    #(HALF);
    SS = 1'b1;
    #(HALF * 2);
    chk("rst_mid frame_done", 32'(fd_cnt - fd0), 32'd0);
    fb[0] = 8'h0B; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame(3, 0, "post_rst_devid");

    // Random frames.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0)
        load_smp(8'($urandom), 8'($urandom), 8'($urandom));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: fb[0] = 8'h0A;
        4, 5, 6, 7: fb[0] = 8'h0B;
        default: begin
          fb[0] = 8'($urandom_range(0, 255));
          if (fb[0] == 8'h0A || fb[0] == 8'h0B) fb[0] = 8'hF0;
        end
      endcase
      case ($urandom_range(0, 5))
        0: fb[1] = 8'h2D;
        1: fb[1] = 8'h3F;
        2: fb[1] = 8'h00;
        3: fb[1] = 8'h08;
        4: fb[1] = 8'($urandom_range(64, 255));
        default: fb[1] = 8'($urandom_range(0, 63));
      endcase
      for (int k = 2; k < 8; k++) fb[k] = 8'($urandom);
      fn = $urandom_range(2, 5);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(fn, part, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(5ms);
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
